// File: rtl/db_multi_fsm.sv
// rtl/db_multi_fsm.sv - multi-channel switch debouncer, shared tick prescaler, per-channel FSM
// Optional long-press pulse compiled in with DB_LONG_PRESS_EN.
module db_multi_fsm #(
   parameter int CH           = 4,
   parameter int TICK_W       = 19,
   parameter int STABLE_TICKS = 3,
   parameter int LP_TICKS     = 100
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [CH-1:0] sw,
   output logic [CH-1:0] db,
   output logic [CH-1:0] rise_tick,
   output logic [CH-1:0] fall_tick,
   output logic [CH-1:0] long_press
);

   localparam int MAX_T = (STABLE_TICKS > LP_TICKS) ? STABLE_TICKS : LP_TICKS;
   localparam int CW    = $clog2(MAX_T + 1);

   // db is state[1], so the level output is a plain register bit
   localparam logic [1:0] ZERO  = 2'b00;
   localparam logic [1:0] WAIT1 = 2'b01;
   localparam logic [1:0] ONE   = 2'b10;
   localparam logic [1:0] WAIT0 = 2'b11;

   localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);

   logic [CH-1:0]     sync1;
   logic [CH-1:0]     s;
   logic [TICK_W-1:0] pre;
   logic              tick;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         s     <= '0;
         pre   <= '0;
      end else begin
         sync1 <= sw;
         s     <= sync1;
         pre   <= pre + 1'b1;
      end
   end

   assign tick = &pre;

   genvar g;
   generate
      for (g = 0; g < CH; g++) begin : g_ch
         logic [1:0]    state;
         logic [CW-1:0] cnt;
         logic          rise_r;
         logic          fall_r;
         logic          enter_one;
         logic          enter_zero;

         assign enter_one  = (state == WAIT1) && s[g]  && tick && (cnt == STABLE_LAST);
         assign enter_zero = (state == WAIT0) && !s[g] && tick && (cnt == STABLE_LAST);

         // A bounce back in a WAIT state wins over a coincident tick
         always_ff @(posedge clk) begin
            if (reset) begin
               state  <= ZERO;
               cnt    <= '0;
               rise_r <= 1'b0;
               fall_r <= 1'b0;
            end else begin
               rise_r <= enter_one;
               fall_r <= enter_zero;
               case (state)
                  ZERO: begin
                     if (s[g]) begin
                        state <= WAIT1;
                        cnt   <= '0;
                     end
                  end
                  WAIT1: begin
                     if (!s[g]) begin
                        state <= ZERO;
                     end else if (enter_one) begin
                        state <= ONE;
                        cnt   <= '0;
                     end else if (tick) begin
                        cnt <= cnt + 1'b1;
                     end
                  end
                  ONE: begin
                     if (!s[g]) begin
                        state <= WAIT0;
                        cnt   <= '0;
                     end
                  end
                  default: begin
                     if (s[g]) begin
                        state <= ONE;
                     end else if (enter_zero) begin
                        state <= ZERO;
                        cnt   <= '0;
                     end else if (tick) begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               endcase
            end
         end

         assign db[g]        = state[1];
         assign rise_tick[g] = rise_r;
         assign fall_tick[g] = fall_r;

`ifdef DB_LONG_PRESS_EN
         localparam logic [CW-1:0] LP_LAST = CW'(LP_TICKS - 1);
         localparam logic [CW-1:0] LP_SAT  = CW'(LP_TICKS);

         logic [CW-1:0] lp_cnt;
         logic          lp_r;

         // Held across a WAIT0 bounce-back; saturates so the pulse fires once per press
         always_ff @(posedge clk) begin
            if (reset) begin
               lp_cnt <= '0;
               lp_r   <= 1'b0;
            end else begin
               lp_r <= 1'b0;
               if (enter_one) begin
                  lp_cnt <= '0;
               end else if ((state == ONE) && s[g] && tick && (lp_cnt != LP_SAT)) begin
                  if (lp_cnt == LP_LAST) begin
                     lp_r   <= 1'b1;
                     lp_cnt <= LP_SAT;
                  end else begin
                     lp_cnt <= lp_cnt + 1'b1;
                  end
               end
            end
         end

         assign long_press[g] = lp_r;
`endif
      end
   endgenerate

`ifndef DB_LONG_PRESS_EN
   assign long_press = '0;
`endif

endmodule

// File: tb/tb_db_multi_fsm.sv
// tb/tb_db_multi_fsm.sv - scoreboard bench for db_multi_fsm (CH=4, TICK_W=4, STABLE_TICKS=3, LP_TICKS=5)
// Build with or without DB_LONG_PRESS_EN to match the RTL build.
module tb_db_multi_fsm;

   localparam int P   = 16;
   localparam int S   = 3;
   localparam int LPT = 5;
   // Pulse window in cycles from stimulus: sync + FSM entry latency on top of tick quantisation
   localparam int QLO = (S - 1) * P;
   localparam int QHI = S * P + 3;
   localparam int LPD = LPT * P;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] sw = 4'hF;
   logic [3:0] db;
   logic [3:0] rise_tick;
   logic [3:0] fall_tick;
   logic [3:0] long_press;

   db_multi_fsm #(
      .CH(4),
      .TICK_W(4),
      .STABLE_TICKS(S),
      .LP_TICKS(LPT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .sw(sw),
      .db(db),
      .rise_tick(rise_tick),
      .fall_tick(fall_tick),
      .long_press(long_press)
   );

   always #5 clk = ~clk;

   typedef struct {
      int ch;
      int kind;
      int lo;
      int hi;
   } ev_t;

   ev_t sb[$];
   int  cyc = 0;
   int  rel = 0;
   int  n_cmp = 0;
   int  n_bad = 0;
   int  last_rise[4] = '{-1, -2, -3, -4};
   int  mi;
   logic mp;

   always @(posedge clk) cyc = cyc + 1;

   task automatic push_ev(input int ch, input int kind, input int dlo, input int dhi);
      ev_t e;
      e.ch = ch;
      e.kind = kind;
      e.lo = cyc + dlo;
      e.hi = cyc + dhi;
      sb.push_back(e);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // kind 0 = rise_tick, 1 = fall_tick, 2 = long_press
   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 3; k++) begin
            mp = (k == 0) ? rise_tick[c] : (k == 1) ? fall_tick[c] : long_press[c];
            if (mp === 1'b1) begin
               n_cmp++;
               mi = -1;
               for (int j = 0; j < sb.size(); j++)
                  if (mi < 0 && sb[j].ch == c && sb[j].kind == k) mi = j;
               if (mi < 0) begin
                  n_bad++;
                  $display("FAIL unexpected_pulse kind=%0d ch=%0d cyc=%0d: got pulse, required none", k, c, cyc);
               end else begin
                  if (cyc < sb[mi].lo || cyc > sb[mi].hi) begin
                     n_bad++;
                     $display("FAIL pulse_window kind=%0d ch=%0d: got cyc %0d, required %0d..%0d",
                              k, c, cyc, sb[mi].lo, sb[mi].hi);
                  end
                  sb.delete(mi);
               end
               if (k == 0) last_rise[c] = cyc;
            end
         end
      end
   end

   task automatic test_reset;
      reset = 1'b1;
      sw = 4'hF;
      repeat (3) begin
         @(negedge clk);
         n_cmp++;
         if ({db, rise_tick, fall_tick, long_press} !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, required 0000", {db, rise_tick, fall_tick, long_press});
         end
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      rel = cyc;
      for (int c = 0; c < 4; c++) begin
         push_ev(c, 0, QLO, QHI);
`ifdef DB_LONG_PRESS_EN
         push_ev(c, 2, QLO + LPD, QHI + LPD);
`endif
      end
      step(60);
      @(negedge clk);
      n_cmp++;
      if (db !== 4'hF) begin
         n_bad++;
         $display("FAIL reset_release_db: got %h, required f", db);
      end
      for (int c = 1; c < 4; c++) begin
         n_cmp++;
         if (last_rise[c] !== last_rise[0]) begin
            n_bad++;
            $display("FAIL rise_same_cycle ch%0d: got cyc %0d, required %0d", c, last_rise[c], last_rise[0]);
         end
      end
      step(100);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL reset_missing_events: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_bounce;
      step(1);
      sw[0] = 1'b0;
      push_ev(0, 1, QLO, QHI);
      step(60);
      for (int i = 0; i < 20; i++) begin
         sw[0] = ~sw[0];
         step(10);
      end
      step(60);
      @(negedge clk);
      n_cmp++;
      if (db[0] !== 1'b0) begin
         n_bad++;
         $display("FAIL bounce_db0: got %b, required 0", db[0]);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL bounce_missing_events: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_rise_fall;
      step(1);
      sw[1] = 1'b0;
      push_ev(1, 1, QLO, QHI);
      step(60);
      sw[1] = 1'b1;
      push_ev(1, 0, QLO, QHI);
      step(60);
      @(negedge clk);
      n_cmp++;
      if (db[1] !== 1'b1) begin
         n_bad++;
         $display("FAIL rise_db1: got %b, required 1", db[1]);
      end
      step(1);
      sw[1] = 1'b0;
      push_ev(1, 1, QLO, QHI);
      step(60);
      @(negedge clk);
      n_cmp++;
      if (db[1] !== 1'b0) begin
         n_bad++;
         $display("FAIL fall_db1: got %b, required 0", db[1]);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL rise_fall_missing_events: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_hold_glitch;
      bit hold_ok;
      hold_ok = 1'b1;
      step(1);
      sw[2] = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (db[2] !== 1'b1) hold_ok = 1'b0;
      end
      @(posedge clk);
      #1;
      sw[2] = 1'b1;
      repeat (60) begin
         @(negedge clk);
         if (db[2] !== 1'b1) hold_ok = 1'b0;
      end
      n_cmp++;
      if (!hold_ok) begin
         n_bad++;
         $display("FAIL hold_db2: got a 0 on db[2], required constant 1");
      end
   endtask

   task automatic test_reset_abort;
      step(1);
      sw[3] = 1'b0;
      push_ev(3, 1, QLO, QHI);
      step(60);
      while ((cyc - rel) % P != 0) step(1);
      // Two ticks into WAIT1 (cnt=2), one tick short of qualifying
      sw[3] = 1'b1;
      step(40);
      reset = 1'b1;
      step(1);
      reset = 1'b0;
      rel = cyc;
      for (int c = 2; c < 4; c++) begin
         push_ev(c, 0, QLO, QHI);
`ifdef DB_LONG_PRESS_EN
         push_ev(c, 2, QLO + LPD, QHI + LPD);
`endif
      end
      @(negedge clk);
      n_cmp++;
      if (db !== 4'h0) begin
         n_bad++;
         $display("FAIL abort_db: got %h, required 0", db);
      end
      step(60);
      @(negedge clk);
      n_cmp++;
      if (db !== 4'hC) begin
         n_bad++;
         $display("FAIL abort_requal_db: got %h, required c", db);
      end
      step(100);
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL abort_missing_events: got %0d pending, required 0", sb.size());
      end
   endtask

   task automatic test_long_press;
      int lp_seen;
      int lp_exp;
      lp_seen = 0;
`ifdef DB_LONG_PRESS_EN
      lp_exp = 1;
`else
      lp_exp = 0;
`endif
      step(1);
      sw[0] = 1'b1;
      push_ev(0, 0, QLO, QHI);
`ifdef DB_LONG_PRESS_EN
      push_ev(0, 2, QLO + LPD, QHI + LPD);
`endif
      repeat (200) begin
         @(negedge clk);
         if (long_press !== 4'h0) lp_seen++;
      end
      n_cmp++;
      if (lp_seen != lp_exp) begin
         n_bad++;
         $display("FAIL long_press_count: got %0d pulse cycles, required %0d", lp_seen, lp_exp);
      end
      n_cmp++;
      if (db[0] !== 1'b1) begin
         n_bad++;
         $display("FAIL long_press_db0: got %b, required 1", db[0]);
      end
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL long_press_missing_events: got %0d pending, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_rise_fall();
      test_hold_glitch();
      test_reset_abort();
      test_long_press();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
